// File: rtl/l2_mem_responder.sv
// In-order L2/memory responder: queues every command beat and services the head after LATENCY cycles.
// Optional macro L2_MEM_PATTERN_EN sets each store line's reset value to {16{32'hA5A5_0000 | i}} instead of 0.
module l2_mem_responder #(
    parameter int LATENCY = 4,
    parameter int QDEPTH  = 4,
    parameter int IDX_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        l2_cmd_valid,
    input  logic [2:0]                  l2_cmd_type,
    input  logic [63:0]                 l2_cmd_addr,
    input  logic [511:0]                l2_cmd_data,
    input  logic [3:0]                  l2_cmd_size,
    input  logic                        l2_cmd_dirty,
    output logic                        l2_response_valid,
    output logic [511:0]                l2_response_data,
    output logic                        l2_response_error,
    output logic [$clog2(QDEPTH):0]     queue_count,
    output logic                        overflow
);
    localparam int PW    = $clog2(QDEPTH);
    localparam int CW    = PW + 1;
    localparam int LINES = 1 << IDX_W;

    typedef struct packed {
        logic [2:0]   ctype;
        logic [63:0]  addr;
        logic [511:0] data;
        logic [3:0]   size;
        logic         dirty;
    } cmd_t;

    cmd_t           q [QDEPTH];
    logic [511:0]   store [LINES];
    logic [PW-1:0]  head, tail;
    logic [3:0]     wait_cnt;
    logic           pop, push, bad, is_read, is_write;
    cmd_t           hd;
    logic [IDX_W-1:0] idx;

    function automatic logic [511:0] init_line(int i);
`ifdef L2_MEM_PATTERN_EN
        return {16{32'hA5A5_0000 | 32'(i)}};
`else
        return '0;
`endif
    endfunction

    always_comb begin
        hd       = q[head];
        pop      = (queue_count != '0) && (wait_cnt == 4'(LATENCY - 1));
        // a full queue still accepts when the head leaves on the same edge
        push     = l2_cmd_valid && ((queue_count < CW'(QDEPTH)) || pop);
        bad      = (hd.ctype > 3'd1) || (hd.size != 4'd6) || (hd.addr[5:0] != 6'd0)
                   || ((hd.addr >> (6 + IDX_W)) != 64'd0);
        is_read  = !bad && (hd.ctype == 3'd0);
        is_write = !bad && (hd.ctype == 3'd1);
        idx      = hd.addr[6 +: IDX_W];
    end

    // payload storage carries no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push)
            q[tail] <= '{ctype: l2_cmd_type, addr: l2_cmd_addr, data: l2_cmd_data,
                         size: l2_cmd_size, dirty: l2_cmd_dirty};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head              <= '0;
            tail              <= '0;
            queue_count       <= '0;
            wait_cnt          <= '0;
            overflow          <= 1'b0;
            l2_response_valid <= 1'b0;
            l2_response_data  <= '0;
            l2_response_error <= 1'b0;
            for (int i = 0; i < LINES; i++)
                store[i] <= init_line(i);
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            queue_count <= queue_count + CW'(push) - CW'(pop);
            if (l2_cmd_valid && !push)
                overflow <= 1'b1;

            if (pop)
                wait_cnt <= '0;
            else if (queue_count != '0)
                wait_cnt <= wait_cnt + 4'd1;

            l2_response_valid <= pop;
            l2_response_error <= pop && bad;
            l2_response_data  <= (pop && is_read) ? store[idx] : '0;
            if (pop && is_write && hd.dirty)
                store[idx] <= hd.data;
        end
    end
endmodule

// File: tb/tb_l2_mem_responder.sv
// Bench for l2_mem_responder: vector table, hand sequences, and random traffic against a completion-time model.
module tb_l2_mem_responder;
    localparam int LAT = 4;
    localparam int QD  = 4;
    localparam int IW  = 4;
    localparam int NL  = 1 << IW;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [2:0]   cmd_type = '0;
    logic [63:0]  cmd_addr = '0;
    logic [511:0] cmd_data = '0;
    logic [3:0]   cmd_size = 4'd6;
    logic         cmd_dirty = 1'b0;
    logic         rsp_valid, rsp_error, ovf;
    logic [511:0] rsp_data;
    logic [2:0]   qcount;

    always #5 clk = ~clk;

    l2_mem_responder #(.LATENCY(LAT), .QDEPTH(QD), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .l2_cmd_valid(cmd_valid), .l2_cmd_type(cmd_type), .l2_cmd_addr(cmd_addr),
        .l2_cmd_data(cmd_data), .l2_cmd_size(cmd_size), .l2_cmd_dirty(cmd_dirty),
        .l2_response_valid(rsp_valid), .l2_response_data(rsp_data),
        .l2_response_error(rsp_error), .queue_count(qcount), .overflow(ovf)
    );

    typedef struct {
        logic [511:0] d;
        logic         e;
    } resp_t;

    typedef struct {
        logic [2:0]   t;
        logic [63:0]  a;
        logic [511:0] d;
        logic [3:0]   s;
        logic         dirty;
        logic         eerr;
        logic [511:0] edata;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    int edge_n = 0, last_comp = 0, resp_seen = 0;
    int pend[$];
    resp_t rq[$];
    logic [511:0] mstore [NL];
    bit evld, eerr, movf;
    logic [511:0] edat;
    logic [511:0] ONES = {512{1'b1}};
    logic [511:0] DB   = {16{32'hDEADBEEF}};

    function automatic logic [511:0] init_line(int i);
`ifdef L2_MEM_PATTERN_EN
        return {16{32'hA5A5_0000 | 32'(i)}};
`else
        return '0;
`endif
    endfunction

    task automatic cmp(string name, logic [511:0] act, logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Each accepted command completes LAT edges after the later of its own
    // accept edge and its predecessor's completion; results follow program order.
    task automatic model_edge();
        resp_t r;
        int comp;
        logic bad;
        int idx;
        evld = 0; edat = '0; eerr = 0;
        if (pend.size() > 0 && pend[0] == edge_n) begin
            void'(pend.pop_front());
            r = rq.pop_front();
            evld = 1; edat = r.d; eerr = r.e;
        end
        if (cmd_valid) begin
            if (pend.size() < QD) begin
                comp = ((edge_n > last_comp) ? edge_n : last_comp) + LAT;
                last_comp = comp;
                pend.push_back(comp);
                bad = (cmd_type > 3'd1) || (cmd_size != 4'd6) || (cmd_addr[5:0] != 0)
                      || ((cmd_addr >> (6 + IW)) != 64'd0);
                idx = int'(cmd_addr[9:6]);
                r.d = '0; r.e = bad;
                if (!bad && cmd_type == 3'd0) r.d = mstore[idx];
                if (!bad && cmd_type == 3'd1 && cmd_dirty) mstore[idx] = cmd_data;
                rq.push_back(r);
            end else
                movf = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        if (rsp_valid) resp_seen++;
        cmp("valid", 512'(rsp_valid), 512'(evld));
        cmp("data", rsp_data, edat);
        cmp("error", 512'(rsp_error), 512'(eerr));
        cmp("queue_count", 512'(qcount), 512'(pend.size()));
        cmp("overflow", 512'(ovf), 512'(movf));
    endtask

    task automatic set_cmd(logic [2:0] t, logic [63:0] a, logic [511:0] d, logic [3:0] s, logic dy);
        cmd_valid = 1; cmd_type = t; cmd_addr = a; cmd_data = d; cmd_size = s; cmd_dirty = dy;
    endtask

    task automatic idle();
        cmd_valid = 0;
    endtask

    task automatic do_reset();
        #1 rst_n = 0;
        #1;
        cmp("rst_valid", 512'(rsp_valid), 512'(0));
        cmp("rst_data", rsp_data, '0);
        cmp("rst_error", 512'(rsp_error), 512'(0));
        cmp("rst_count", 512'(qcount), 512'(0));
        cmp("rst_overflow", 512'(ovf), 512'(0));
        pend.delete(); rq.delete();
        last_comp = 0; movf = 0; edge_n = 0;
        for (int i = 0; i < NL; i++) mstore[i] = init_line(i);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
    endtask

    function automatic vec_t mk(logic [2:0] t, logic [63:0] a, logic [511:0] d, logic [3:0] s,
                                logic dy, logic ee, logic [511:0] ed);
        vec_t v;
        v.t = t; v.a = a; v.d = d; v.s = s; v.dirty = dy; v.eerr = ee; v.edata = ed;
        return v;
    endfunction

    task automatic rand_cmd();
        logic [63:0] a;
        logic [511:0] d;
        logic [2:0] t;
        int k;
        k = $urandom_range(0, 19);
        t = (k == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
        a = {54'd0, 4'($urandom_range(0, NL - 1)), 6'd0};
        if (k == 1) a[5:0] = 6'($urandom_range(1, 63));
        if (k == 2) a[40] = 1'b1;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
        set_cmd(t, a, d, (k == 3) ? 4'd5 : 4'd6, 1'($urandom_range(0, 1)));
    endtask

    vec_t tv[12];

    initial begin
        tv[0]  = mk(3'd0, 64'h40,  '0,   4'd6, 1'b0, 1'b0, init_line(1));
        tv[1]  = mk(3'd1, 64'h80,  DB,   4'd6, 1'b1, 1'b0, '0);
        tv[2]  = mk(3'd0, 64'h80,  '0,   4'd6, 1'b0, 1'b0, DB);
        tv[3]  = mk(3'd1, 64'hC0,  ONES, 4'd6, 1'b0, 1'b0, '0);
        tv[4]  = mk(3'd0, 64'hC0,  '0,   4'd6, 1'b0, 1'b0, init_line(3));
        tv[5]  = mk(3'd5, 64'h100, '0,   4'd6, 1'b0, 1'b1, '0);
        tv[6]  = mk(3'd0, 64'h100, '0,   4'd3, 1'b0, 1'b1, '0);
        tv[7]  = mk(3'd0, 64'h41,  '0,   4'd6, 1'b0, 1'b1, '0);
        tv[8]  = mk(3'd1, 64'h1_0000_0000, ONES, 4'd6, 1'b1, 1'b1, '0);
        tv[9]  = mk(3'd0, 64'h0,   '0,   4'd6, 1'b0, 1'b0, init_line(0));
        tv[10] = mk(3'd1, 64'h100, ONES, 4'd3, 1'b1, 1'b1, '0);
        tv[11] = mk(3'd0, 64'h100, '0,   4'd6, 1'b0, 1'b0, init_line(4));

        do_reset();

        // READ accepted at edge 10 responds only in the cycle after edge 14
        repeat (9) tick();
        set_cmd(3'd0, 64'h40, '0, 4'd6, 1'b0);
        tick();
        idle();
        for (int k = 11; k <= 15; k++) begin
            tick();
            cmp("lat_valid", 512'(rsp_valid), 512'(k == 14));
            if (k == 14) cmp("lat_data", rsp_data, init_line(1));
        end

        foreach (tv[i]) begin
            set_cmd(tv[i].t, tv[i].a, tv[i].d, tv[i].s, tv[i].dirty);
            tick();
            idle();
            repeat (LAT) tick();
            cmp($sformatf("vec%0d_valid", i), 512'(rsp_valid), 512'(1));
            cmp($sformatf("vec%0d_error", i), 512'(rsp_error), 512'(tv[i].eerr));
            cmp($sformatf("vec%0d_data", i), rsp_data, tv[i].edata);
        end

        // back-to-back WRITE then READ of the same line, responses 4 apart
        do_reset();
        set_cmd(3'd1, 64'h80, DB, 4'd6, 1'b1);
        tick();
        set_cmd(3'd0, 64'h80, '0, 4'd6, 1'b0);
        tick();
        idle();
        for (int k = 3; k <= 9; k++) begin
            tick();
            cmp("b2b_valid", 512'(rsp_valid), 512'(k == 5 || k == 9));
            if (k == 9) cmp("b2b_data", rsp_data, DB);
        end

        // six back-to-back READs into a 4-deep queue
        do_reset();
        resp_seen = 0;
        for (int k = 1; k <= 6; k++) begin
            set_cmd(3'd0, 64'(k) << 6, '0, 4'd6, 1'b0);
            tick();
            if (k == 4) cmp("ovf_peak_count", 512'(qcount), 512'(4));
            if (k == 5) cmp("ovf_on_pop_edge", 512'(ovf), 512'(0));
        end
        idle();
        cmp("ovf_set", 512'(ovf), 512'(1));
        repeat (30) tick();
        cmp("ovf_sticky", 512'(ovf), 512'(1));
        cmp("ovf_resp_count", 512'(resp_seen), 512'(5));

        // reset while three commands are queued
        for (int k = 0; k < 3; k++) begin
            set_cmd(3'd0, 64'h40, '0, 4'd6, 1'b0);
            tick();
        end
        idle();
        do_reset();
        resp_seen = 0;
        repeat (20) tick();
        cmp("flush_no_resp", 512'(resp_seen), 512'(0));

        // random traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) != 0) rand_cmd();
            else idle();
            tick();
        end
        idle();
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
